// File: rtl/tpu_host_pkg.sv
// Shared constants for the TPU host sequencer: FSM state codes, pin-control
// bit positions and small helpers that build the uio_in control word.
package tpu_host_pkg;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_LOAD = 3'd1;
    localparam logic [2:0] ST_WAIT = 3'd2;
    localparam logic [2:0] ST_READ = 3'd3;
    localparam logic [2:0] ST_RESP = 3'd4;

    localparam int LOAD_EN_BIT = 0;
    localparam int SEL_AB_BIT  = 1;
    localparam int IDX_LSB     = 2;
    localparam int OUT_EN_BIT  = 4;
    localparam int OUT_SEL_LSB = 5;

    localparam int NUM_ELEMS  = 4;
    localparam int LOAD_BEATS = 8;

    function automatic logic [6:0] load_ctrl(input logic sel_ab, input logic [1:0] idx);
        logic [6:0] c;
        c                 = '0;
        c[LOAD_EN_BIT]    = 1'b1;
        c[SEL_AB_BIT]     = sel_ab;
        c[IDX_LSB +: 2]   = idx;
        return c;
    endfunction

    function automatic logic [6:0] read_ctrl(input logic [1:0] sel);
        logic [6:0] c;
        c                   = '0;
        c[OUT_EN_BIT]       = 1'b1;
        c[OUT_SEL_LSB +: 2] = sel;
        return c;
    endfunction

endpackage

// File: rtl/tpu_host_seq.sv
// Host-side initiator for the TPU pin protocol: loads A and B, waits for done,
// reads four result bytes. Define TPU_HOST_TIMEOUT_EN to enable the WAIT watchdog.
module tpu_host_seq
    import tpu_host_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int READ_LAT = 1,
    parameter int TIMEOUT  = 255
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    input  logic [NUM_ELEMS*DATA_W-1:0]   a_flat,
    input  logic [NUM_ELEMS*DATA_W-1:0]   b_flat,
    output logic                          busy,
    output logic [NUM_ELEMS*DATA_W-1:0]   res_flat,
    output logic                          res_valid,
    output logic                          err_timeout,
    output logic [DATA_W-1:0]             pin_data_out,
    output logic [6:0]                    pin_ctrl_out,
    input  logic [DATA_W-1:0]             pin_data_in,
    input  logic                          pin_done_in
);

    localparam int VEC_W = NUM_ELEMS * DATA_W;

    logic [2:0]              state;
    logic [2:0]              beat;
    logic [2:0]              beat_next;
    logic [1:0]              rd_sel;
    logic [1:0]              rd_sel_next;
    logic [1:0]              lat_cnt;
    logic                    done_armed;
    logic                    done_qual;
    logic                    timeout_hit;
    logic [VEC_W-1:0]        a_reg;
    logic [VEC_W-1:0]        b_reg;
    logic [VEC_W-DATA_W-1:0] res_buf;
    logic [DATA_W-1:0]       next_elem;

    assign beat_next   = beat + 3'd1;
    assign rd_sel_next = rd_sel + 2'd1;
    assign done_qual   = done_armed & pin_done_in;
    assign next_elem   = beat_next[2] ? b_reg[int'(beat_next[1:0])*DATA_W +: DATA_W]
                                      : a_reg[int'(beat_next[1:0])*DATA_W +: DATA_W];

`ifdef TPU_HOST_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT + 1);

    logic [TO_W-1:0] wait_cnt;

    assign timeout_hit = (wait_cnt == TO_W'(TIMEOUT - 1));

    // Counter is zero outside WAIT, so every WAIT visit starts counting from 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt    <= '0;
            err_timeout <= 1'b0;
        end else begin
            wait_cnt <= (state == ST_WAIT) ? wait_cnt + TO_W'(1) : '0;
            if (state == ST_IDLE && start)
                err_timeout <= 1'b0;
            else if (state == ST_WAIT && !done_qual && timeout_hit)
                err_timeout <= 1'b1;
        end
    end
`else
    logic unused_timeout;

    assign timeout_hit    = 1'b0;
    assign err_timeout    = 1'b0;
    assign unused_timeout = (TIMEOUT > 0);
`endif

    // Pin outputs are loaded with the value for the state being entered,
    // so the TPU sees each beat for a full cycle straight after the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            beat         <= '0;
            rd_sel       <= '0;
            lat_cnt      <= '0;
            done_armed   <= 1'b0;
            a_reg        <= '0;
            b_reg        <= '0;
            res_buf      <= '0;
            res_flat     <= '0;
            res_valid    <= 1'b0;
            busy         <= 1'b0;
            pin_data_out <= '0;
            pin_ctrl_out <= '0;
        end else begin
            res_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        a_reg        <= a_flat;
                        b_reg        <= b_flat;
                        beat         <= '0;
                        done_armed   <= 1'b0;
                        busy         <= 1'b1;
                        pin_ctrl_out <= load_ctrl(1'b0, 2'd0);
                        pin_data_out <= a_flat[DATA_W-1:0];
                        state        <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    if (!pin_done_in)
                        done_armed <= 1'b1;
                    if (beat == 3'(LOAD_BEATS - 1)) begin
                        pin_ctrl_out <= '0;
                        pin_data_out <= '0;
                        state        <= ST_WAIT;
                    end else begin
                        beat         <= beat_next;
                        pin_ctrl_out <= load_ctrl(beat_next[2], beat_next[1:0]);
                        pin_data_out <= next_elem;
                    end
                end
                ST_WAIT: begin
                    // A done level seen before any low sample is stale and ignored.
                    if (!pin_done_in)
                        done_armed <= 1'b1;
                    if (done_qual) begin
                        rd_sel       <= '0;
                        lat_cnt      <= '0;
                        pin_ctrl_out <= read_ctrl(2'd0);
                        state        <= ST_READ;
                    end else if (timeout_hit) begin
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end
                end
                ST_READ: begin
                    if (lat_cnt == 2'(READ_LAT)) begin
                        lat_cnt <= '0;
                        if (rd_sel == 2'(NUM_ELEMS - 1)) begin
                            res_flat     <= {pin_data_in, res_buf};
                            res_valid    <= 1'b1;
                            pin_ctrl_out <= '0;
                            state        <= ST_RESP;
                        end else begin
                            res_buf[int'(rd_sel)*DATA_W +: DATA_W] <= pin_data_in;
                            rd_sel       <= rd_sel_next;
                            pin_ctrl_out <= read_ctrl(rd_sel_next);
                        end
                    end else begin
                        lat_cnt <= lat_cnt + 2'd1;
                    end
                end
                ST_RESP: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    busy         <= 1'b0;
                    pin_ctrl_out <= '0;
                    pin_data_out <= '0;
                    state        <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tpu_host_seq.sv
// Scoreboard bench for tpu_host_seq with a behavioural TPU pin model.
// Build with TPU_HOST_TIMEOUT_EN to exercise the watchdog path.
module tb_tpu_host_seq;

    localparam int RL      = 2;
    localparam int TO      = 20;
    localparam int LOAD_EN = 0;
    localparam int SEL_AB  = 1;
    localparam int OUT_EN  = 4;

    typedef struct {
        logic [31:0] res;
        int          cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [31:0] a_flat;
    logic [31:0] b_flat;
    logic        busy;
    logic [31:0] res_flat;
    logic        res_valid;
    logic        err_timeout;
    logic [7:0]  pin_data_out;
    logic [6:0]  pin_ctrl_out;
    logic [7:0]  pin_data_in = 8'h00;
    logic        pin_done_in = 1'b0;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          cur_d = 0;
    int          done_mode = 0;
    int          done_cycle = 0;
    bit          done_pend = 1'b0;
    logic [7:0]  tpu_mem [8];
    logic [7:0]  hist [RL];
    logic [7:0]  fval;
    logic [31:0] cres;
    exp_t        exp_q [$];
    logic [10:0] beat_q [$];
    int          run_len = 0;
    int          run_sel = 0;

    tpu_host_seq #(
        .DATA_W   (8),
        .READ_LAT (RL),
        .TIMEOUT  (TO)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .a_flat       (a_flat),
        .b_flat       (b_flat),
        .busy         (busy),
        .res_flat     (res_flat),
        .res_valid    (res_valid),
        .err_timeout  (err_timeout),
        .pin_data_out (pin_data_out),
        .pin_ctrl_out (pin_ctrl_out),
        .pin_data_in  (pin_data_in),
        .pin_done_in  (pin_done_in)
    );

    always #5 clk = ~clk;

    // C = A x B on signed int8 elements, each result byte truncated to 8 bits.
    function automatic logic [31:0] matmul2x2(input logic [31:0] a, input logic [31:0] b);
        logic [31:0] r;
        int          acc;
        for (int i = 0; i < 2; i++) begin
            for (int j = 0; j < 2; j++) begin
                acc = $signed(a[(2*i)*8 +: 8]) * $signed(b[j*8 +: 8])
                    + $signed(a[(2*i+1)*8 +: 8]) * $signed(b[(2+j)*8 +: 8]);
                r[(2*i+j)*8 +: 8] = acc[7:0];
            end
        end
        return r;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    task automatic pushBeats(input logic [31:0] a, input logic [31:0] b);
        for (int k = 0; k < 8; k++)
            beat_q.push_back({(k >= 4) ? 1'b1 : 1'b0, 2'(k % 4),
                              (k < 4) ? a[k*8 +: 8] : b[(k-4)*8 +: 8]});
    endtask

    // Behavioural TPU: stores load beats, raises done cur_d cycles after the
    // last beat, drops done on any new load, and returns results RL cycles late.
    always @(posedge clk) begin
        cyc++;
        if (pin_ctrl_out[LOAD_EN]) begin
            tpu_mem[{pin_ctrl_out[SEL_AB], pin_ctrl_out[3:2]}] = pin_data_out;
            done_pend = 1'b0;
            if (pin_ctrl_out[SEL_AB] && pin_ctrl_out[3:2] == 2'd3) begin
                done_pend  = 1'b1;
                done_cycle = cyc + cur_d;
            end
        end
        cres = matmul2x2({tpu_mem[3], tpu_mem[2], tpu_mem[1], tpu_mem[0]},
                         {tpu_mem[7], tpu_mem[6], tpu_mem[5], tpu_mem[4]});
        fval = pin_ctrl_out[OUT_EN] ? cres[int'(pin_ctrl_out[6:5])*8 +: 8] : 8'hEE;
        for (int i = RL - 1; i > 0; i--)
            hist[i] = hist[i-1];
        hist[0] = fval;
        pin_data_in <= hist[RL-1];
        case (done_mode)
            1:       pin_done_in <= 1'b1;
            2:       pin_done_in <= 1'b0;
            default: pin_done_in <= done_pend && (cyc >= done_cycle);
        endcase
    end

    // Monitor: load beats, read-select hold times and result pulses.
    always @(negedge clk) begin
        if (!rst_n) begin
            run_len = 0;
        end else begin
            if (pin_ctrl_out[LOAD_EN]) begin
                if (beat_q.size() == 0)
                    checkOutput("unexpected_load_beat", pin_ctrl_out[LOAD_EN], 1'b0);
                else
                    checkOutput("load_beat", {pin_ctrl_out[SEL_AB], pin_ctrl_out[3:2], pin_data_out},
                                beat_q.pop_front());
            end
            if (pin_ctrl_out[OUT_EN]) begin
                if (run_len > 0 && int'(pin_ctrl_out[6:5]) == run_sel) begin
                    run_len++;
                end else begin
                    if (run_len > 0)
                        checkOutput("sel_hold", run_len, RL + 1);
                    checkOutput("sel_order", pin_ctrl_out[6:5], (run_len > 0) ? run_sel + 1 : 0);
                    run_sel = int'(pin_ctrl_out[6:5]);
                    run_len = 1;
                end
            end else if (run_len > 0) begin
                checkOutput("sel_hold", run_len, RL + 1);
                run_len = 0;
            end
            if (res_valid) begin
                if (exp_q.size() == 0) begin
                    checkOutput("unexpected_res_valid", res_valid, 1'b0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    checkOutput("res_flat", res_flat, e.res);
                    checkOutput("res_latency", cyc, e.cyc);
                end
            end
        end
    end

    task automatic doReset();
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("async_reset_outputs",
                    {busy, res_valid, err_timeout, res_flat, pin_data_out, pin_ctrl_out}, 64'd0);
        exp_q.delete();
        beat_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b, input int d, input bit poke);
        exp_t e;
        bit   read_poked;
        int   n;
        read_poked = 1'b0;
        pushBeats(a, b);
        e.res = matmul2x2(a, b);
        e.cyc = cyc + 10 + d + 4 * (RL + 1);
        exp_q.push_back(e);
        cur_d  = d;
        a_flat = a;
        b_flat = b;
        start  = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        a_flat = $urandom;
        b_flat = $urandom;
        checkOutput("busy_on_accept", busy, 1'b1);
        checkOutput("err_clear_on_accept", err_timeout, 1'b0);
        n = 0;
        while (busy && n < 400) begin
            start = 1'b0;
            if (poke && n == 3)
                start = 1'b1;
            if (poke && !read_poked && pin_ctrl_out[OUT_EN]) begin
                start      = 1'b1;
                read_poked = 1'b1;
            end
            n++;
            @(negedge clk);
        end
        start = 1'b0;
        if (busy)
            checkOutput("cmd_complete", busy, 1'b0);
    endtask

    task automatic resetInRead();
        logic [31:0] a;
        logic [31:0] b;
        exp_t        e;
        int          n;
        a = $urandom;
        b = $urandom;
        n = 0;
        pushBeats(a, b);
        e.res = matmul2x2(a, b);
        e.cyc = cyc + 14 + 4 * (RL + 1);
        exp_q.push_back(e);
        cur_d  = 4;
        a_flat = a;
        b_flat = b;
        start  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        while (!(pin_ctrl_out[OUT_EN] && pin_ctrl_out[6:5] == 2'd2) && n < 200) begin
            n++;
            @(negedge clk);
        end
        checkOutput("reached_third_read", pin_ctrl_out[OUT_EN], 1'b1);
        doReset();
    endtask

    task automatic runNoDone(input int mode);
        logic [31:0] a;
        logic [31:0] b;
        int          n;
        a = $urandom;
        b = $urandom;
        n = 0;
        done_mode = mode;
        pushBeats(a, b);
        a_flat = a;
        b_flat = b;
        start  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        while (busy && n < 100) begin
            n++;
            @(negedge clk);
        end
`ifdef TPU_HOST_TIMEOUT_EN
        checkOutput("timeout_busy_cycles", n, 8 + TO);
        checkOutput("timeout_err_set", err_timeout, 1'b1);
        checkOutput("timeout_idle", busy, 1'b0);
        repeat (3) @(negedge clk);
        checkOutput("timeout_err_sticky", err_timeout, 1'b1);
`else
        checkOutput("hang_busy", busy, 1'b1);
        checkOutput("hang_err_tied", err_timeout, 1'b0);
        doReset();
`endif
        done_mode = 0;
    endtask

    initial begin
        rst_n  = 1'b0;
        start  = 1'b0;
        a_flat = '0;
        b_flat = '0;
        for (int i = 0; i < 8; i++)
            tpu_mem[i] = 8'h00;
        for (int i = 0; i < RL; i++)
            hist[i] = 8'h00;
        repeat (3) @(negedge clk);
        checkOutput("reset_state",
                    {busy, res_valid, err_timeout, res_flat, pin_data_out, pin_ctrl_out}, 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        $display("[TB] basic load");
        applyStimulus({8'd4, 8'd3, 8'd2, 8'd1}, {8'd8, 8'd7, 8'd6, 8'd5}, 10, 1'b0);
        $display("[TB] stale done from previous command");
        applyStimulus($urandom, $urandom, 3, 1'b0);
        $display("[TB] ignored start pulses");
        applyStimulus($urandom, $urandom, 5, 1'b1);
        $display("[TB] reset during READ");
        resetInRead();
        applyStimulus($urandom, $urandom, 0, 1'b0);
        $display("[TB] done held high");
        runNoDone(1);
`ifdef TPU_HOST_TIMEOUT_EN
        $display("[TB] done never rises");
        runNoDone(2);
`endif
        $display("[TB] random commands");
        for (int t = 0; t < 6; t++)
            applyStimulus($urandom, $urandom, int'($urandom_range(0, 12)), t[0]);
        repeat (2) @(negedge clk);
        checkOutput("exp_q_drained", exp_q.size(), 0);
        checkOutput("beat_q_drained", beat_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL global_timeout actual=running required=finished");
        $fatal(1, "[TB] simulation time limit");
    end

endmodule
